mux_sel_buffered: RTL
=====================

# mux_sel_buffered

Parametrised successor to the datapath source multiplexers. It selects one of `N_IN` data channels, or a built-in constant channel such as the PC+4 increment, under a selector. The selected word is captured on a valid/ready handshake into a small in-order buffer, which decouples the selecting stage from the consuming stage of the multicycle datapath. Out-of-range selectors are defined rather than left as don't-care: they fall back to channel 0 and raise a sticky error flag.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits
- `N_IN`, 5, number of selectable channels (2..16)
- `SEL_W`, 3, selector width; must satisfy 2^SEL_W >= N_IN
- `CONST_IDX`, 1, channel index that returns `CONST_VAL` instead of its data input
- `CONST_VAL`, 4, constant value, zero-extended to `WIDTH`
- `DEPTH`, 2, number of buffer entries (1..8)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `sel`  in  SEL_W  channel selector, sampled on accept
- `data_in`  in  N_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH]
- `in_valid`  in  1  producer presents `sel`/`data_in`
- `in_ready`  out  1  buffer can accept this cycle
- `data_out`  out  WIDTH  head-of-buffer word
- `sel_out`  out  SEL_W  effective channel index of the head entry (after fallback)
- `out_valid`  out  1  head entry present
- `out_ready`  in  1  consumer takes the head
- `sel_err`  out  1  sticky flag: an out-of-range selector was accepted

## Operation
- Accept occurs when `in_valid && in_ready`.
- On accept, the selection rule is:
  - `sel == CONST_IDX` → the captured word is `CONST_VAL`.
  - `sel < N_IN` → the captured word is channel `sel`.
  - Otherwise → the captured word is channel 0, `sel_out` for that entry is 0, and `sel_err` is set.
- Pop occurs when `out_valid && out_ready`; the head advances.
- Occupancy counter `count` runs 0..DEPTH:
  - push only → +1
  - pop only → −1
  - push and pop together → unchanged
- `in_ready = (count != DEPTH)`. It is decoded from registered state only and does not depend on `out_ready`. As a result, a full buffer refuses input even in a cycle where it is popping.
- `out_valid = (count != 0)`.
- When `out_valid` is 0, `data_out` and `sel_out` are driven to 0.
- Read/write pointers are `$clog2(DEPTH)` wide, or 1 bit when DEPTH=1. Each pointer wraps to 0 after DEPTH−1; wrap must be explicit, which matters for non-power-of-two DEPTH.
- `sel_err` clears only on `reset`.
- Empty buffer with simultaneous accept: the entry becomes visible the next cycle. There is no combinational bypass.

## Timing
- Latency: a word accepted at edge t appears on `data_out` with `out_valid=1` after edge t, i.e. one cycle.
- Throughput: 1 word/cycle while `count < DEPTH` and the consumer pops every cycle.
- Reset values (after any edge with `reset=1`): `count=0`, pointers 0, `out_valid=0`, `in_ready=1`, `data_out=0`, `sel_out=0`, `sel_err=0`.
- Reset has priority over push and pop in the same cycle.
- Reset mid-operation discards all buffered entries; no pop is reported for them.
- `data_out` and `sel_out` are stable while `out_valid && !out_ready`.
- The producer must hold `sel`/`data_in` stable while `in_valid && !in_ready`.

## Structure
- Package `mux_pkg` holds:
  - `PC_INCR = 32'd4` (default for `CONST_VAL`)
  - the selector encodings used by the control unit: `SEL_PC=0`, `SEL_INCR=1`, `SEL_ALU=2`, `SEL_ALUOUT=3`, `SEL_EPC=4`
  - a function `sel_in_range(sel, n)`
- Sub-module `mux_fifo` (parameters `WIDTH+SEL_W`, `DEPTH`) is the natural split. It contains the storage, pointers, count and ready/valid.
- The top level contains:
  - the combinational channel select
  - the constant injection
  - the range check and `sel_err` register

## Test plan
- Reset then idle → `in_ready=1`, `out_valid=0`, `data_out=0`, `sel_err=0`.
- Channel select and constant injection:
  - Stimulus: `sel=1` with `data_in` channel 1=0xDEADBEEF, then `sel=3` with channel 3=0x12345678; `out_ready=1`.
  - Response: outputs `0x00000004` (`sel_out=1`), then `0x12345678` (`sel_out=3`), each one cycle after accept.
- Fill and backpressure (DEPTH=2):
  - Stimulus: push 0xA, 0xB with `out_ready=0`.
  - Response: `in_ready=0` after the second accept; a third `in_valid` is held off. Asserting `out_ready` pops 0xA then 0xB in order.
- Out-of-range selector:
  - Stimulus: `sel=7` with channel 0=0x55.
  - Response: outputs 0x55 with `sel_out=0`; `sel_err=1` and it stays 1 through subsequent valid transfers until `reset`.
- Simultaneous push/pop:
  - Stimulus: `count=1` with `in_valid=out_ready=1` for 4 cycles.
  - Response: `count` stays 1 and words come out in order, each one cycle after accept.
- Reset mid-operation:
  - Stimulus: assert `reset` with 2 entries buffered.
  - Response: next cycle `out_valid=0`, `in_ready=1`, `data_out=0`; the old entries never appear.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the datapath source multiplexers: selector encodings,
// the PC increment constant and the selector range check.
package mux_pkg;

    localparam logic [31:0] PC_INCR = 32'd4;

    // Selector encodings driven by the control unit.
    typedef enum logic [2:0] {
        SEL_PC     = 3'd0,
        SEL_INCR   = 3'd1,
        SEL_ALU    = 3'd2,
        SEL_ALUOUT = 3'd3,
        SEL_EPC    = 3'd4
    } sel_e;

    function automatic logic sel_in_range(input logic [31:0] sel, input int n);
        return (sel < 32'(n));
    endfunction

endpackage

// File: rtl/mux_fifo.sv
// In-order buffer with explicit pointer wrap, occupancy counter and
// ready/valid decoded purely from registered state.
module mux_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] push_data,
    input  logic         push_valid,
    output logic         push_ready,
    output logic [W-1:0] pop_data,
    output logic         pop_valid,
    input  logic         pop_ready
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Wrap is explicit so non-power-of-two depths never step past DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign push_ready = (count != CNT_W'(DEPTH));
    assign pop_valid  = (count != '0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mux_sel_buffered.sv
// Channel/constant source multiplexer whose selected word is captured into a
// small in-order buffer; out-of-range selectors fall back to channel 0.
module mux_sel_buffered
    import mux_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          N_IN      = 5,
    parameter int          SEL_W     = 3,
    parameter int          CONST_IDX = 1,
    parameter logic [31:0] CONST_VAL = PC_INCR,
    parameter int          DEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    localparam logic [WIDTH-1:0] CONST_WORD = WIDTH'(CONST_VAL);

    logic                   in_range;
    logic                   is_const;
    logic [SEL_W-1:0]       eff_sel;
    logic [WIDTH-1:0]       chan_word;
    logic [WIDTH-1:0]       sel_word;
    logic [SEL_W+WIDTH-1:0] push_entry;
    logic [SEL_W+WIDTH-1:0] head_entry;
    logic                   accept;

    assign in_range = sel_in_range(32'(sel), N_IN);
    assign is_const = (sel == SEL_W'(CONST_IDX));
    assign eff_sel  = in_range ? sel : '0;

    always_comb begin
        chan_word = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                chan_word = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_word   = is_const ? CONST_WORD : chan_word;
    assign push_entry = {eff_sel, sel_word};

    // A transfer happens on a side exactly in a cycle where valid and ready
    // are both high at the rising edge; in_ready depends only on registered
    // occupancy, so a full buffer refuses input even while it is popping.
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && !in_range) begin
            sel_err <= 1'b1;
        end
    end

    mux_fifo #(
        .W     (SEL_W + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_data  (push_entry),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .pop_data   (head_entry),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready)
    );

    assign data_out = head_entry[WIDTH-1:0];
    assign sel_out  = head_entry[WIDTH +: SEL_W];

endmodule
